simple_axi_master: RTL and testbench
====================================

// Module: simple_axi_master
// PURPOSE
//   Bridges a level-driven host request bus to one AXI4 master port. Each host
//   request becomes exactly one single-beat AXI read or write. Sits between a
//   simple CPU/controller and an AXI interconnect or slave.
//   The block holds o_done until the host acknowledges it with i_clear_done.
// PARAMETERS
//   DATA_WIDTH  32  data bus width in bits; must be a multiple of 8
//   ADDR_WIDTH  32  address bus width in bits
// PORTS
//   i_clk           in   1     single clock; all logic on rising edge
//   i_rst           in   1     synchronous, active-high reset
//   i_addr          in   AW    host address; latched at request accept
//   i_wdata         in   DW    host write data; latched at request accept
//   o_rdata         out  DW    read data; registered on R handshake
//   i_rw            in   2     00 idle, 01 write, 10 read, 11 invalid
//   o_wait          out  1     high while a transaction is in flight
//   o_done          out  1     sticky completion flag
//   i_clear_done    in   1     host ack; clears done/invalid/error
//   o_invalid       out  1     sticky; set when i_rw=11 is requested
//   o_error         out  1     sticky; set on BRESP/RRESP != 2'b00
//   m_axi_aw*/ar*   AW: awvalid o, awready i, awaddr o[AW], awsize o[3],
//                   awburst o[2], awcache o[4], awprot o[3], awlen o[8],
//                   awlock o[1], awqos o[4]; AR uses the identical set
//   m_axi_wvalid o 1, wready i 1, wlast o 1, wdata o DW, wstrb o DW/8
//   m_axi_bvalid i 1, bready o 1, bresp i 2
//   m_axi_rvalid i 1, rready o 1, rlast i 1, rdata i DW, rresp i 2
// BEHAVIOUR
//   - Reset: every valid/ready output is 0; o_rdata=0.
//     o_wait, o_done, o_invalid and o_error are 0. State is IDLE.
//   - Constant AXI fields: len=0, size=log2(DW/8) (3'b010 for DW=32),
//     burst=INCR 2'b01, cache=4'b0011, prot=0, lock=0, qos=0.
//     wstrb is all ones and wlast=1.
//   - State IDLE, o_done=0:
//     * i_rw=01: latch addr/wdata, go to WR_AW_W.
//     * i_rw=10: latch addr, go to RD_AR.
//     * i_rw=11: set o_invalid and o_done, go to DONE; no AXI activity.
//     * i_rw=00: stay in IDLE.
//   - WR_AW_W: drive awvalid and wvalid together from registers.
//     Each valid drops the cycle after its own handshake (valid&ready).
//     A separate flag records each completed channel. Go to WR_B when both
//     channels have completed, including when both complete in the same cycle.
//   - WR_B: drive bready=1. On bvalid&bready, set o_error if bresp!=0, then go
//     to DONE.
//   - RD_AR: drive arvalid until arvalid&arready, then go to RD_R.
//   - RD_R: drive rready=1. On rvalid&rready, register o_rdata<=rdata and set
//     o_error if rresp!=0, then go to DONE. rlast is ignored (single beat).
//   - DONE: o_done=1. The block ignores i_rw and never re-launches while
//     o_done=1.
//     i_clear_done=1 clears o_done/o_invalid/o_error and returns to IDLE next
//     cycle. o_rdata holds its value until the next read.
//   - o_wait=1 in WR_AW_W, WR_B, RD_AR and RD_R; otherwise 0.
//   - i_clear_done outside DONE is ignored.
//   - Valids never drop before their handshake (AXI stability rule).
//   - Host inputs that change mid-transaction have no effect.
//   - Reset mid-transaction aborts at once to the reset state; no outstanding
//     tracking.
//   - Latency: with a zero-wait slave, done follows accept in 3 cycles or fewer.
//     With the team slave model (1-cycle-late ready/valid), done is asserted
//     within 6 cycles.
// TESTING
//   1. Write: addr=0x1000_0000, wdata=0xCAFEBABE, rw=01 -> awaddr/wdata show
//      these values, awlen=0, wlast=1, bready asserted, o_done=1, o_error=0.
//   2. Read: addr=0x2000_0000, rw=10, slave returns 0xDEADBEEF ->
//      araddr=0x2000_0000, o_rdata=0xDEADBEEF, o_done=1.
//   3. Done holding: keep rw=01 after done without clear_done -> no second
//      awvalid. Pulse clear_done with rw=00 -> o_done=0, o_wait=0.
//   4. Error: slave returns bresp=2'b10 on a write -> o_error=1 and o_done=1.
//      Both clear on clear_done.
//   5. Invalid: rw=11 -> o_invalid=1 and o_done=1, no AXI valid ever rises.
//   6. Stalled slave: hold awready=0 for 5 cycles while wready=1 -> awvalid
//      stays high, wvalid drops after its handshake, write still completes.

Source files
------------

// File: rtl/simple_axi_master_if.sv
// ---------------------------------------------------------------------------
// simple_axi_master_if
//   AXI4 channel bundle between simple_axi_master and an AXI slave or
//   interconnect. Only the signals a single-beat master needs are carried.
//   Ports (per channel):
//     AW/AR : valid, ready, addr, size, burst, cache, prot, len, lock, qos
//     W     : valid, ready, last, data, strb
//     B     : valid, ready, resp
//     R     : valid, ready, last, data, resp
//   Modports: master (drives valids/payload, bready/rready),
//             slave  (drives readys, B and R responses).
// ---------------------------------------------------------------------------
interface simple_axi_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    // Write address channel
    logic                    m_axi_awvalid;
    logic                    m_axi_awready;
    logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
    logic [2:0]              m_axi_awsize;
    logic [1:0]              m_axi_awburst;
    logic [3:0]              m_axi_awcache;
    logic [2:0]              m_axi_awprot;
    logic [7:0]              m_axi_awlen;
    logic                    m_axi_awlock;
    logic [3:0]              m_axi_awqos;
    // Write data channel
    logic                    m_axi_wvalid;
    logic                    m_axi_wready;
    logic                    m_axi_wlast;
    logic [DATA_WIDTH-1:0]   m_axi_wdata;
    logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
    // Write response channel
    logic                    m_axi_bvalid;
    logic                    m_axi_bready;
    logic [1:0]              m_axi_bresp;
    // Read address channel
    logic                    m_axi_arvalid;
    logic                    m_axi_arready;
    logic [ADDR_WIDTH-1:0]   m_axi_araddr;
    logic [2:0]              m_axi_arsize;
    logic [1:0]              m_axi_arburst;
    logic [3:0]              m_axi_arcache;
    logic [2:0]              m_axi_arprot;
    logic [7:0]              m_axi_arlen;
    logic                    m_axi_arlock;
    logic [3:0]              m_axi_arqos;
    // Read data channel
    logic                    m_axi_rvalid;
    logic                    m_axi_rready;
    logic                    m_axi_rlast;
    logic [DATA_WIDTH-1:0]   m_axi_rdata;
    logic [1:0]              m_axi_rresp;

    modport master (
        output m_axi_awvalid, m_axi_awaddr, m_axi_awsize, m_axi_awburst,
               m_axi_awcache, m_axi_awprot, m_axi_awlen, m_axi_awlock, m_axi_awqos,
        input  m_axi_awready,
        output m_axi_wvalid, m_axi_wlast, m_axi_wdata, m_axi_wstrb,
        input  m_axi_wready,
        input  m_axi_bvalid, m_axi_bresp,
        output m_axi_bready,
        output m_axi_arvalid, m_axi_araddr, m_axi_arsize, m_axi_arburst,
               m_axi_arcache, m_axi_arprot, m_axi_arlen, m_axi_arlock, m_axi_arqos,
        input  m_axi_arready,
        input  m_axi_rvalid, m_axi_rlast, m_axi_rdata, m_axi_rresp,
        output m_axi_rready
    );

    modport slave (
        input  m_axi_awvalid, m_axi_awaddr, m_axi_awsize, m_axi_awburst,
               m_axi_awcache, m_axi_awprot, m_axi_awlen, m_axi_awlock, m_axi_awqos,
        output m_axi_awready,
        input  m_axi_wvalid, m_axi_wlast, m_axi_wdata, m_axi_wstrb,
        output m_axi_wready,
        output m_axi_bvalid, m_axi_bresp,
        input  m_axi_bready,
        input  m_axi_arvalid, m_axi_araddr, m_axi_arsize, m_axi_arburst,
               m_axi_arcache, m_axi_arprot, m_axi_arlen, m_axi_arlock, m_axi_arqos,
        output m_axi_arready,
        output m_axi_rvalid, m_axi_rlast, m_axi_rdata, m_axi_rresp,
        input  m_axi_rready
    );
endinterface

// File: rtl/simple_axi_master.sv
// ---------------------------------------------------------------------------
// simple_axi_master
//   Turns a level-driven host request (i_rw) into exactly one single-beat
//   AXI4 write or read, then holds a sticky o_done until i_clear_done.
//   Ports:
//     i_clk, i_rst    clock, synchronous active-high reset
//     i_addr, i_wdata host address / write data, latched at request accept
//     i_rw            00 idle, 01 write, 10 read, 11 invalid
//     o_rdata         read data, registered on the R handshake
//     o_wait          high while a transaction is in flight
//     o_done          sticky completion flag
//     i_clear_done    host acknowledge; clears done/invalid/error in DONE
//     o_invalid       sticky, set by an i_rw=11 request
//     o_error         sticky, set by a non-OKAY BRESP/RRESP
//     m_axi           AXI4 master modport
// ---------------------------------------------------------------------------
module simple_axi_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata,
    input  logic [1:0]            i_rw,
    output logic                  o_wait,
    output logic                  o_done,
    input  logic                  i_clear_done,
    output logic                  o_invalid,
    output logic                  o_error,
    simple_axi_master_if.master   m_axi
);

    localparam int       STRB_W = DATA_WIDTH / 8;
    localparam logic [2:0] AXSIZE = 3'($clog2(STRB_W));

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_AW_W,
        ST_WR_B,
        ST_RD_AR,
        ST_RD_R,
        ST_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_arvalid;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic                  r_invalid;
    logic                  r_error;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_b_hs;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_bready;
    logic                  w_rready;
    logic                  w_wait;
    logic                  w_done;
    logic                  w_unused_rlast;

    // Single-beat transfers: rlast carries no information.
    assign w_unused_rlast = m_axi.m_axi_rlast;

    assign w_aw_hs = r_awvalid & m_axi.m_axi_awready;
    assign w_w_hs  = r_wvalid  & m_axi.m_axi_wready;
    assign w_b_hs  = m_axi.m_axi_bvalid & w_bready;
    assign w_ar_hs = r_arvalid & m_axi.m_axi_arready;
    assign w_r_hs  = m_axi.m_axi_rvalid & w_rready;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_next   = r_state;
        w_bready = 1'b0;
        w_rready = 1'b0;
        w_wait   = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                case (i_rw)
                    2'b01:   w_next = ST_WR_AW_W;
                    2'b10:   w_next = ST_RD_AR;
                    2'b11:   w_next = ST_DONE;
                    default: w_next = ST_IDLE;
                endcase
            end
            ST_WR_AW_W: begin
                w_wait = 1'b1;
                // A channel counts as complete if it finished earlier or
                // handshakes right now, so a same-cycle pair also advances.
                if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
                    w_next = ST_WR_B;
                end
            end
            ST_WR_B: begin
                w_wait   = 1'b1;
                w_bready = 1'b1;
                if (w_b_hs) begin
                    w_next = ST_DONE;
                end
            end
            ST_RD_AR: begin
                w_wait = 1'b1;
                if (w_ar_hs) begin
                    w_next = ST_RD_R;
                end
            end
            ST_RD_R: begin
                w_wait   = 1'b1;
                w_rready = 1'b1;
                if (w_r_hs) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (i_clear_done) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Channel valids, completion flags, sticky status and read data
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_invalid <= 1'b0;
            r_error   <= 1'b0;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_rw == 2'b01) begin
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                    if (i_rw == 2'b10) begin
                        r_arvalid <= 1'b1;
                    end
                    if (i_rw == 2'b11) begin
                        r_invalid <= 1'b1;
                    end
                end
                ST_WR_AW_W: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                end
                ST_WR_B: begin
                    if (w_b_hs && (m_axi.m_axi_bresp != 2'b00)) begin
                        r_error <= 1'b1;
                    end
                end
                ST_RD_AR: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                    end
                end
                ST_RD_R: begin
                    if (w_r_hs) begin
                        r_rdata <= m_axi.m_axi_rdata;
                        if (m_axi.m_axi_rresp != 2'b00) begin
                            r_error <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (i_clear_done) begin
                        r_invalid <= 1'b0;
                        r_error   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Request payload latch; later host changes are ignored until IDLE.
    always_ff @(posedge i_clk) begin
        if ((r_state == ST_IDLE) && ((i_rw == 2'b01) || (i_rw == 2'b10))) begin
            r_addr <= i_addr;
        end
        if ((r_state == ST_IDLE) && (i_rw == 2'b01)) begin
            r_wdata <= i_wdata;
        end
    end

    // Host-side outputs
    assign o_rdata   = r_rdata;
    assign o_wait    = w_wait;
    assign o_done    = w_done;
    assign o_invalid = r_invalid;
    assign o_error   = r_error;

    // AW channel
    assign m_axi.m_axi_awvalid = r_awvalid;
    assign m_axi.m_axi_awaddr  = r_addr;
    assign m_axi.m_axi_awsize  = AXSIZE;
    assign m_axi.m_axi_awburst = 2'b01;
    assign m_axi.m_axi_awcache = 4'b0011;
    assign m_axi.m_axi_awprot  = 3'b000;
    assign m_axi.m_axi_awlen   = 8'd0;
    assign m_axi.m_axi_awlock  = 1'b0;
    assign m_axi.m_axi_awqos   = 4'd0;

    // W channel
    assign m_axi.m_axi_wvalid  = r_wvalid;
    assign m_axi.m_axi_wdata   = r_wdata;
    assign m_axi.m_axi_wstrb   = '1;
    assign m_axi.m_axi_wlast   = 1'b1;

    // B channel
    assign m_axi.m_axi_bready  = w_bready;

    // AR channel
    assign m_axi.m_axi_arvalid = r_arvalid;
    assign m_axi.m_axi_araddr  = r_addr;
    assign m_axi.m_axi_arsize  = AXSIZE;
    assign m_axi.m_axi_arburst = 2'b01;
    assign m_axi.m_axi_arcache = 4'b0011;
    assign m_axi.m_axi_arprot  = 3'b000;
    assign m_axi.m_axi_arlen   = 8'd0;
    assign m_axi.m_axi_arlock  = 1'b0;
    assign m_axi.m_axi_arqos   = 4'd0;

    // R channel
    assign m_axi.m_axi_rready  = w_rready;

endmodule

// File: tb/tb_simple_axi_master.sv
// ---------------------------------------------------------------------------
// tb_simple_axi_master
//   Directed bench for simple_axi_master with a configurable-latency AXI slave
//   and a transaction-level model of what the host and bus must observe.
// ---------------------------------------------------------------------------
module tb_simple_axi_master;

    logic        clk;
    logic        rst;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic [1:0]  i_rw;
    logic        o_wait;
    logic        o_done;
    logic        i_clear_done;
    logic        o_invalid;
    logic        o_error;

    simple_axi_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) axi ();

    simple_axi_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_rdata      (o_rdata),
        .i_rw         (i_rw),
        .o_wait       (o_wait),
        .o_done       (o_done),
        .i_clear_done (i_clear_done),
        .o_invalid    (o_invalid),
        .o_error      (o_error),
        .m_axi        (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- slave configuration and observation ----------------
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
    logic [31:0] s_rdata = 32'h0;

    bit hs_aw, hs_w, hs_b, hs_ar, hs_r;
    int aw_hs_n, w_hs_n, b_hs_n, ar_hs_n, r_hs_n, aw_stall_n, w_stall_n;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;

    always @(posedge clk) begin
        hs_aw <= axi.m_axi_awvalid & axi.m_axi_awready;
        hs_w  <= axi.m_axi_wvalid  & axi.m_axi_wready;
        hs_b  <= axi.m_axi_bvalid  & axi.m_axi_bready;
        hs_ar <= axi.m_axi_arvalid & axi.m_axi_arready;
        hs_r  <= axi.m_axi_rvalid  & axi.m_axi_rready;
        if (axi.m_axi_awvalid & axi.m_axi_awready) begin
            aw_hs_n    <= aw_hs_n + 1;
            cap_awaddr <= axi.m_axi_awaddr;
        end
        if (axi.m_axi_wvalid & axi.m_axi_wready) begin
            w_hs_n    <= w_hs_n + 1;
            cap_wdata <= axi.m_axi_wdata;
        end
        if (axi.m_axi_bvalid & axi.m_axi_bready) b_hs_n <= b_hs_n + 1;
        if (axi.m_axi_arvalid & axi.m_axi_arready) begin
            ar_hs_n    <= ar_hs_n + 1;
            cap_araddr <= axi.m_axi_araddr;
        end
        if (axi.m_axi_rvalid & axi.m_axi_rready) r_hs_n <= r_hs_n + 1;
        if (axi.m_axi_awvalid & !axi.m_axi_awready) aw_stall_n <= aw_stall_n + 1;
        if (axi.m_axi_wvalid & !axi.m_axi_wready) w_stall_n <= w_stall_n + 1;
    end

    // Slave responder: changes its outputs on the falling edge only.
    initial begin
        int  aw_c, w_c, b_c, ar_c, r_c;
        bit  got_aw, got_w, got_ar;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        got_aw = 0; got_w = 0; got_ar = 0;
        axi.m_axi_awready = 1'b0; axi.m_axi_wready = 1'b0; axi.m_axi_arready = 1'b0;
        axi.m_axi_bvalid = 1'b0;  axi.m_axi_bresp = 2'b00;
        axi.m_axi_rvalid = 1'b0;  axi.m_axi_rresp = 2'b00;
        axi.m_axi_rlast = 1'b0;   axi.m_axi_rdata = 32'h0BAD_F00D;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
                got_aw = 0; got_w = 0; got_ar = 0;
                axi.m_axi_awready = 1'b0; axi.m_axi_wready = 1'b0; axi.m_axi_arready = 1'b0;
                axi.m_axi_bvalid = 1'b0;  axi.m_axi_rvalid = 1'b0; axi.m_axi_rlast = 1'b0;
            end else begin
                if (axi.m_axi_awvalid) begin axi.m_axi_awready = (aw_c >= aw_dly); aw_c++; end
                else begin axi.m_axi_awready = 1'b0; aw_c = 0; end
                if (axi.m_axi_wvalid) begin axi.m_axi_wready = (w_c >= w_dly); w_c++; end
                else begin axi.m_axi_wready = 1'b0; w_c = 0; end
                if (axi.m_axi_arvalid) begin axi.m_axi_arready = (ar_c >= ar_dly); ar_c++; end
                else begin axi.m_axi_arready = 1'b0; ar_c = 0; end
                if (hs_aw) got_aw = 1;
                if (hs_w)  got_w = 1;
                if (hs_ar) got_ar = 1;
                if (hs_b) begin
                    axi.m_axi_bvalid = 1'b0; got_aw = 0; got_w = 0; b_c = 0;
                end else if (got_aw && got_w && !axi.m_axi_bvalid) begin
                    if (b_c >= b_dly) begin axi.m_axi_bvalid = 1'b1; axi.m_axi_bresp = s_bresp; end
                    else b_c++;
                end
                if (hs_r) begin
                    axi.m_axi_rvalid = 1'b0; axi.m_axi_rlast = 1'b0;
                    axi.m_axi_rdata = 32'h0BAD_F00D; got_ar = 0; r_c = 0;
                end else if (got_ar && !axi.m_axi_rvalid) begin
                    if (r_c >= r_dly) begin
                        axi.m_axi_rvalid = 1'b1; axi.m_axi_rlast = 1'b1;
                        axi.m_axi_rdata = s_rdata; axi.m_axi_rresp = s_rresp;
                    end else r_c++;
                end
            end
        end
    end

    // ---------------- transaction model ----------------
    logic        busy_w = 0, busy_r = 0, hold = 0, exp_invalid = 0, exp_error = 0;
    logic [31:0] exp_addr = 0, exp_wdata = 0;

    // Per-cycle compare against the model, 2 time units after the rising edge.
    initial begin
        logic        p_aw, p_w, p_ar;
        logic [31:0] p_awaddr, p_wdata;
        p_aw = 0; p_w = 0; p_ar = 0; p_awaddr = 0; p_wdata = 0;
        forever begin
            @(posedge clk); #2;
            if (!busy_w || hold)
                chk("no_write_activity", {axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_bready}, 0);
            if (!busy_r || hold)
                chk("no_read_activity", {axi.m_axi_arvalid, axi.m_axi_rready}, 0);
            if (axi.m_axi_awvalid)
                chk("aw_fields", {axi.m_axi_awaddr, axi.m_axi_awlen, axi.m_axi_awsize, axi.m_axi_awburst,
                                  axi.m_axi_awcache, axi.m_axi_awprot, axi.m_axi_awlock, axi.m_axi_awqos},
                                 {exp_addr, 8'h00, 3'd2, 2'b01, 4'b0011, 3'b000, 1'b0, 4'h0});
            if (axi.m_axi_wvalid)
                chk("w_fields", {axi.m_axi_wdata, axi.m_axi_wstrb, axi.m_axi_wlast}, {exp_wdata, 4'hF, 1'b1});
            if (axi.m_axi_arvalid)
                chk("ar_fields", {axi.m_axi_araddr, axi.m_axi_arlen, axi.m_axi_arsize, axi.m_axi_arburst,
                                  axi.m_axi_arcache, axi.m_axi_arprot, axi.m_axi_arlock, axi.m_axi_arqos},
                                 {exp_addr, 8'h00, 3'd2, 2'b01, 4'b0011, 3'b000, 1'b0, 4'h0});
            // A valid seen last cycle must persist until its handshake and drop right after it.
            if (!rst && p_aw) begin
                chk("awvalid_rule", axi.m_axi_awvalid, !axi.m_axi_awready);
                if (!axi.m_axi_awready) chk("awaddr_stable", axi.m_axi_awaddr, p_awaddr);
            end
            if (!rst && p_w) begin
                chk("wvalid_rule", axi.m_axi_wvalid, !axi.m_axi_wready);
                if (!axi.m_axi_wready) chk("wdata_stable", axi.m_axi_wdata, p_wdata);
            end
            if (!rst && p_ar) chk("arvalid_rule", axi.m_axi_arvalid, !axi.m_axi_arready);
            if (busy_w || busy_r) begin
                chk("wait_vs_done", o_wait, !o_done);
                if (!o_done) chk("no_early_error", o_error, 0);
            end else begin
                chk("wait_idle", o_wait, 0);
            end
            if (hold)
                chk("done_status", {o_done, o_invalid, o_error}, {1'b1, exp_invalid, exp_error});
            else if (!busy_w && !busy_r)
                chk("idle_status", {o_done, o_invalid, o_error}, 3'b000);
            p_aw = axi.m_axi_awvalid; p_w = axi.m_axi_wvalid; p_ar = axi.m_axi_arvalid;
            p_awaddr = axi.m_axi_awaddr; p_wdata = axi.m_axi_wdata;
        end
    end

    // ---------------- host tasks ----------------
    task automatic accept(input logic [1:0] rw, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit hold_rw);
        @(negedge clk);
        i_rw = rw; i_addr = addr; i_wdata = wdata;
        @(posedge clk); #1;
        exp_addr = addr; exp_wdata = wdata;
        busy_w = (rw == 2'b01);
        busy_r = (rw == 2'b10);
        if (rw == 2'b11) begin exp_invalid = 1; exp_error = 0; hold = 1; end
        @(negedge clk);
        if (!hold_rw) i_rw = 2'b00;
        i_addr = ~addr; i_wdata = ~wdata;
    endtask

    task automatic wait_done(input int max_lat);
        int n;
        bit got;
        n = 0; got = 0;
        while (n < 40 && !got) begin
            @(posedge clk); #1;
            n++;
            if (o_done) got = 1;
        end
        chk("done_reached", got, 1);
        if (got) begin
            chk("latency_within_bound", (n <= max_lat), 1);
            exp_invalid = 0;
            exp_error = busy_w ? (s_bresp != 2'b00) : (s_rresp != 2'b00);
            hold = 1;
        end
    endtask

    task automatic clear();
        @(negedge clk);
        i_clear_done = 1'b1; i_rw = 2'b00;
        @(posedge clk); #1;
        busy_w = 0; busy_r = 0; hold = 0; exp_invalid = 0; exp_error = 0;
        @(negedge clk);
        i_clear_done = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 300000");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int a0, w0, b0, ar0, s0, ws0;
        rst = 1'b1; i_rw = 2'b00; i_addr = 0; i_wdata = 0; i_clear_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_host_out", {o_rdata, o_wait, o_done, o_invalid, o_error}, 0);
        chk("reset_axi_out", {axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_bready,
                              axi.m_axi_arvalid, axi.m_axi_rready}, 0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);

        // Zero-wait write
        a0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
        accept(2'b01, 32'h1000_0000, 32'hCAFE_BABE, 0);
        wait_done(3);
        chk("t1_awaddr", cap_awaddr, 32'h1000_0000);
        chk("t1_wdata", cap_wdata, 32'hCAFE_BABE);
        chk("t1_one_beat_each", {8'(aw_hs_n - a0), 8'(w_hs_n - w0), 8'(b_hs_n - b0)}, 24'h010101);
        chk("t1_done_noerr", {o_done, o_error}, 2'b10);
        clear();

        // Zero-wait read
        s_rdata = 32'hDEAD_BEEF;
        accept(2'b10, 32'h2000_0000, 32'h0, 0);
        wait_done(3);
        chk("t2_araddr", cap_araddr, 32'h2000_0000);
        chk("t2_rdata", o_rdata, 32'hDEAD_BEEF);
        chk("t2_done", o_done, 1);
        clear();
        chk("t2_rdata_held", o_rdata, 32'hDEAD_BEEF);

        // Done holding with the write request still asserted
        a0 = aw_hs_n;
        accept(2'b01, 32'h1000_0040, 32'h1234_5678, 1);
        wait_done(3);
        repeat (6) @(negedge clk);
        chk("t3_no_relaunch", aw_hs_n - a0, 1);
        clear();
        #1;
        chk("t3_cleared", {o_done, o_wait}, 2'b00);
        repeat (3) @(negedge clk);
        chk("t3_idle_after_clear", aw_hs_n - a0, 1);
        chk("t3_rdata_kept", o_rdata, 32'hDEAD_BEEF);

        // Write error response
        s_bresp = 2'b10;
        accept(2'b01, 32'h1000_0080, 32'h0000_00FF, 0);
        wait_done(3);
        chk("t4_error_set", {o_error, o_done}, 2'b11);
        clear();
        #1;
        chk("t4_error_cleared", {o_error, o_done}, 2'b00);
        s_bresp = 2'b00;

        // Read error response still captures data
        s_rresp = 2'b11; s_rdata = 32'h5555_AAAA;
        accept(2'b10, 32'h2000_0100, 32'h0, 0);
        wait_done(3);
        chk("t4b_rdata", o_rdata, 32'h5555_AAAA);
        chk("t4b_error", o_error, 1);
        clear();
        s_rresp = 2'b00;

        // Invalid request
        a0 = aw_hs_n; w0 = w_hs_n; ar0 = ar_hs_n;
        accept(2'b11, 32'h3000_0000, 32'h0, 0);
        repeat (4) @(negedge clk);
        chk("t5_invalid_done", {o_invalid, o_done, o_wait}, 3'b110);
        chk("t5_no_axi", {8'(aw_hs_n - a0), 8'(w_hs_n - w0), 8'(ar_hs_n - ar0)}, 24'h0);
        clear();
        #1;
        chk("t5_invalid_cleared", o_invalid, 0);

        // Stalled AW with a clear_done pulse mid-flight
        aw_dly = 5;
        a0 = aw_hs_n; w0 = w_hs_n; s0 = aw_stall_n; ws0 = w_stall_n;
        accept(2'b01, 32'h1000_0200, 32'hA1B2_C3D4, 0);
        @(negedge clk); i_clear_done = 1'b1;
        @(negedge clk); i_clear_done = 1'b0;
        wait_done(20);
        chk("t6_aw_stall_cycles", aw_stall_n - s0, 5);
        chk("t6_w_no_stall", w_stall_n - ws0, 0);
        chk("t6_one_beat_each", {8'(aw_hs_n - a0), 8'(w_hs_n - w0)}, 16'h0101);
        chk("t6_payload", {cap_awaddr, cap_wdata}, {32'h1000_0200, 32'hA1B2_C3D4});
        clear();
        aw_dly = 0;

        // One-cycle-late slave on every channel
        aw_dly = 1; w_dly = 1; b_dly = 1; ar_dly = 1; r_dly = 1;
        accept(2'b01, 32'h1000_0300, 32'h0F0F_0F0F, 0);
        wait_done(6);
        chk("t7_wdata", cap_wdata, 32'h0F0F_0F0F);
        clear();
        s_rdata = 32'h1357_9BDF;
        accept(2'b10, 32'h2000_0300, 32'h0, 0);
        wait_done(6);
        chk("t7_rdata", o_rdata, 32'h1357_9BDF);
        clear();
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;

        // Reset in the middle of a stalled write
        aw_dly = 10;
        a0 = aw_hs_n;
        accept(2'b01, 32'h1000_0400, 32'h7777_7777, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        busy_w = 0; busy_r = 0; hold = 0;
        chk("t8_reset_abort", {o_wait, o_done, o_rdata, axi.m_axi_awvalid, axi.m_axi_wvalid}, 0);
        @(negedge clk); rst = 1'b0;
        aw_dly = 0;
        repeat (3) @(negedge clk);
        chk("t8_no_aw_after_reset", aw_hs_n - a0, 0);
        s_rdata = 32'hA5A5_5A5A;
        accept(2'b10, 32'h2000_0400, 32'h0, 0);
        wait_done(3);
        chk("t8_recovered_read", o_rdata, 32'hA5A5_5A5A);
        clear();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
